// File: rtl/kernel_token_driver.sv
// Host-side initiator for an elastic dataflow kernel: issues n/start tokens, collects
// out0/end tokens in any order, and returns result, run latency and a timeout flag.
module kernel_token_driver #(
    parameter int DATA_W  = 8,
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_n,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CYC_W-1:0]  rsp_cycles,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] n,
    output logic              n_valid,
    input  logic              n_ready,
    output logic              start_valid,
    input  logic              start_ready,
    input  logic [DATA_W-1:0] out0,
    input  logic              out0_valid,
    output logic              out0_ready,
    input  logic              end_valid,
    output logic              end_ready
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

    state_t             state;
    state_t             state_next;
    logic               armed;
    logic               sent_n;
    logic               sent_start;
    logic               got_out;
    logic               got_end;
    logic [CYC_W-1:0]   cyc;
    logic [CYC_W-1:0]   cyc_inc;
    logic               req_fire;
    logic               n_fire;
    logic               start_fire;
    logic               out_fire;
    logic               end_fire;
    logic               done;
    logic               timed_out;

    // armed holds req_ready low until the first edge after reset is released
    assign req_ready   = armed && (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign n_valid     = (state == RUN) && !sent_n;
    assign start_valid = (state == RUN) && !sent_start;
    assign out0_ready  = (state == RUN) && !got_out;
    assign end_ready   = (state == RUN) && !got_end;

    assign req_fire   = req_valid && req_ready;
    assign n_fire     = n_valid && n_ready;
    assign start_fire = start_valid && start_ready;
    assign out_fire   = out0_valid && out0_ready;
    assign end_fire   = end_valid && end_ready;

    assign cyc_inc   = (&cyc) ? cyc : cyc + 1'b1;
    assign done      = (sent_n || n_fire) && (sent_start || start_fire) &&
                       (got_out || out_fire) && (got_end || end_fire);
    assign timed_out = (cyc_inc == TIMEOUT_C) && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = RUN;
            RUN:     if (done || timed_out) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Completion takes priority over timeout when both land in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b0;
            n           <= '0;
            sent_n      <= 1'b0;
            sent_start  <= 1'b0;
            got_out     <= 1'b0;
            got_end     <= 1'b0;
            cyc         <= '0;
            rsp_data    <= '0;
            rsp_cycles  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (req_fire) begin
                n           <= req_n;
                sent_n      <= 1'b0;
                sent_start  <= 1'b0;
                got_out     <= 1'b0;
                got_end     <= 1'b0;
                cyc         <= '0;
                rsp_data    <= '0;
                rsp_cycles  <= '0;
                rsp_timeout <= 1'b0;
            end else if (state == RUN) begin
                cyc <= cyc_inc;
                if (n_fire)     sent_n     <= 1'b1;
                if (start_fire) sent_start <= 1'b1;
                if (out_fire)   got_out    <= 1'b1;
                if (end_fire)   got_end    <= 1'b1;
                if (out_fire)   rsp_data   <= out0;
                if (done) begin
                    rsp_cycles  <= cyc_inc;
                    rsp_timeout <= 1'b0;
                end else if (timed_out) begin
                    rsp_cycles  <= TIMEOUT_C;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule
